dmem_lsu: RTL
=============

# dmem_lsu

Data-memory stage with integrated load/store unit for the RISC-V core. It sits directly downstream of the ALU: the ALU result is the effective byte address, and rs2 supplies the store data. The block performs byte/halfword/word stores with byte enables, and sign- or zero-extended loads. It also detects misaligned or illegal-width accesses, suppresses them, and records the first offending address.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words; must be a power of two.
- IDX_W, log2(DEPTH_WORDS) = 12: word-index width.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  byte address (ALU out).
- wdata  in  32  store data (rs2).
- mem_read  in  1  load request this cycle.
- mem_write  in  1  store request this cycle.
- funct3  in  3  RISC-V width code.
- rdata  out  32  load result (combinational).
- misaligned  out  1  current access is misaligned or illegal (combinational).
- err_sticky  out  1  set once any faulting access has occurred.
- err_addr  out  32  address of the first faulting access since reset.
- err_count  out  8  number of faulting accesses, saturating at 255.

## Operation
- Word index is addr[IDX_W+1:2]. Upper address bits are ignored, so accesses wrap modulo 4·DEPTH_WORDS bytes.
- Load codes:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
- Store codes:
  - 000 SB: byte wdata[7:0] to lane addr[1:0].
  - 001 SH: wdata[15:0] to lanes {addr[1],0}.
  - 010 SW: full word.
- Little-endian: lane 0 is bits [7:0].
- Fault conditions (misaligned=1). These are evaluated only when mem_read or mem_write is high:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - funct3 ∈ {011,110,111};
  - store with funct3 ∈ {100,101}.
- On a faulting store, memory is unchanged. On a faulting load, rdata=0.
- When mem_read=0, rdata=0 and misaligned reflects the store only.
- When mem_read=mem_write=0, misaligned=0.
- Error tracking, on each rising edge with rst=0 and misaligned=1:
  - err_count increments, saturating at 255.
  - If err_sticky=0: err_sticky←1 and err_addr←addr. Later faults do not overwrite err_addr.
- Memory contents are zero at time 0 and are never altered by rst.

## Timing
- Stores commit on the rising edge at the end of the cycle in which mem_write=1, the access does not fault, and rst=0. Store latency is 1 cycle.
- Loads are combinational from the current array contents, with zero added cycles.
- Simultaneous mem_read and mem_write to the same word: rdata returns the pre-store data that cycle; the new data is visible from the next cycle.
- A load in the cycle after a store to the same word returns the stored data.
- Reset values: err_sticky=0, err_addr=0, err_count=0. rdata and misaligned remain purely combinational.
- rst high with mem_write high: the store is suppressed and the error registers clear. Reset wins over fault capture in the same edge.
- Reset asserted mid-sequence does not corrupt previously committed stores.
- Fault capture at 255 faults: err_count holds at 255; err_sticky and err_addr are unchanged.

## Test plan
- Reset, then idle. Required: err_sticky=0, err_addr=0, err_count=0, rdata=0 while mem_read=0.
- SW 0x8000_00FF to addr 0x10, then LB/LBU/LH/LHU/LW at 0x10. Required: 0xFFFF_FFFF, 0x0000_00FF, 0x0000_00FF, 0x0000_00FF, 0x8000_00FF.
- SB 0xAB to 0x13, then LW at 0x10. Required: 0xAB00_00FF. Then SH 0x1234 to 0x12, then LW. Required: 0x1234_00FF.
- Same-cycle SW 0x5555_5555 plus LW at 0x20, with the word previously 0. Required: rdata=0 that cycle; LW next cycle returns 0x5555_5555.
- LW at 0x22, then SH at 0x31, then funct3=011 load at 0x40. Required:
  - misaligned=1 each cycle; rdata=0 on the loads;
  - memory at 0x30 unchanged;
  - err_addr=0x22, err_count=3, err_sticky=1.
- 300 faulting accesses: err_count saturates at 255. Then a store with rst=1: no memory write, and all error outputs return to 0 on that edge.
- Address wrap: SW to 0x4000 (DEPTH_WORDS=4096), then LW at 0x0. Required: the stored value is returned.

Source files
------------

// File: rtl/dmem_lsu.sv
// Data-memory stage with load/store unit: byte/half/word stores with byte enables,
// sign/zero-extended loads, and fault detection with first-fault address capture.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic [IDX_W-1:0] word_idx;
  logic             unused_addr_hi;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             illegal;
  logic             align_bad;
  logic [3:0]       be;
  logic [31:0]      wval;
  logic             store_en;

  // Upper address bits are deliberately ignored so accesses wrap around the array.
  assign word_idx       = addr[IDX_W+1:2];
  assign unused_addr_hi = ^addr[31:IDX_W+2];

  assign rd_word = mem_q[word_idx];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    unique case (addr[1:0])
      2'b00: rd_byte = rd_word[7:0];
      2'b01: rd_byte = rd_word[15:8];
      2'b10: rd_byte = rd_word[23:16];
      2'b11: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (mem_write && funct3[2]);
    align_bad  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    misaligned = (mem_read || mem_write) && (illegal || align_bad);
  end

  always_comb begin
    rdata = '0;
    if (mem_read && !misaligned) begin
      case (funct3)
        3'b000: rdata = {{24{rd_byte[7]}}, rd_byte};
        3'b001: rdata = {{16{rd_half[15]}}, rd_half};
        3'b010: rdata = rd_word;
        3'b100: rdata = {24'b0, rd_byte};
        3'b101: rdata = {16'b0, rd_half};
        default: rdata = '0;
      endcase
    end
  end

  // Store data is replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    be   = 4'b0000;
    wval = '0;
    case (funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        wval = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        wval = {2{wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b1111;
        wval = wdata;
      end
      default: begin
        be   = 4'b0000;
        wval = '0;
      end
    endcase
  end

  assign store_en = mem_write && !misaligned && !rst;

  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wval[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
      err_count  <= '0;
    end else if (misaligned) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (!err_sticky) begin
        err_sticky <= 1'b1;
        err_addr   <= addr;
      end
    end
  end

endmodule
